// File: rtl/bcd_stopwatch_if.sv
// Control and display bundle between the stopwatch and its neighbours:
// slow clock and buttons in, BCD value and status out.
interface bcd_stopwatch_if;
   logic        slowClk;
   logic        startStop;
   logic        lap;
   logic        clear;
   logic [15:0] display;
   logic        running;
   logic        lapActive;
   logic        overflow;

   modport master (
      output slowClk, startStop, lap, clear,
      input  display, running, lapActive, overflow
   );

   modport slave (
      input  slowClk, startStop, lap, clear,
      output display, running, lapActive, overflow
   );
endinterface

// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch driven by ticks recovered from an asynchronous
// slow square wave, with start/stop, lap-freeze and clear controls.
module bcdDigit (
   input  logic [3:0] d,
   input  logic       cin,
   output logic [3:0] q,
   output logic       cout
);
   assign cout = cin & (d == 4'd9);
   assign q    = cin ? (cout ? 4'd0 : d + 4'd1) : d;
endmodule

module bcd_stopwatch #(
   parameter int TICKS_PER_COUNT = 1
) (
   input logic       clkIn,
   input logic       rst,
   bcd_stopwatch_if.slave sw
);
   localparam logic [1:0] STOPPED  = 2'd0;
   localparam logic [1:0] RUNNING  = 2'd1;
   localparam logic [1:0] LAP_HOLD = 2'd2;
   localparam logic [7:0] PRESC_MAX = 8'(TICKS_PER_COUNT - 1);

   logic [1:0]  state, stateNext;
   logic [2:0]  slowSync;
   logic        ssPrev, lapPrev;
   logic [7:0]  presc;
   logic [15:0] count, countInc, dispReg;
   logic [4:0]  carry;
   logic        ovfReg;

   logic tick, ssEdge, lapEdge, active, prescWrap, lapClr;

   assign tick      = slowSync[1] & ~slowSync[2];
   assign ssEdge    = sw.startStop & ~ssPrev;
   assign lapEdge   = sw.lap & ~lapPrev;
   assign active    = (state != STOPPED);
   assign prescWrap = (presc == PRESC_MAX);
   assign carry[0]  = active & tick & prescWrap;
   // ssEdge wins over lapEdge, so a same-cycle pair in STOPPED only starts
   assign lapClr    = (state == STOPPED) & lapEdge & ~ssEdge;

   for (genvar g = 0; g < 4; g++) begin : gDigit
      bcdDigit uDig (
         .d    (count[4*g +: 4]),
         .cin  (carry[g]),
         .q    (countInc[4*g +: 4]),
         .cout (carry[g+1])
      );
   end

   always_comb begin
      stateNext = state;
      case (state)
         STOPPED:  if (ssEdge) stateNext = RUNNING;
         RUNNING:  if (ssEdge) stateNext = STOPPED;
                   else if (lapEdge) stateNext = LAP_HOLD;
         LAP_HOLD: if (ssEdge) stateNext = STOPPED;
                   else if (lapEdge) stateNext = RUNNING;
         default:  stateNext = STOPPED;
      endcase
   end

   always_ff @(posedge clkIn) begin
      if (rst) begin
         slowSync <= '0;
         ssPrev   <= 1'b0;
         lapPrev  <= 1'b0;
         state    <= STOPPED;
         count    <= '0;
         presc    <= '0;
         dispReg  <= '0;
         ovfReg   <= 1'b0;
      end else begin
         slowSync <= {slowSync[1:0], sw.slowClk};
         ssPrev   <= sw.startStop;
         lapPrev  <= sw.lap;
         if (sw.clear || lapClr) begin
            state   <= sw.clear ? STOPPED : stateNext;
            count   <= '0;
            presc   <= '0;
            dispReg <= '0;
            ovfReg  <= 1'b0;
         end else begin
            state <= stateNext;
            count <= countInc;
            if (active && tick) presc <= prescWrap ? 8'd0 : presc + 8'd1;
            if (carry[4]) ovfReg <= 1'b1;
            // Entering LAP_HOLD keeps the pre-increment value already shown
            if (stateNext != LAP_HOLD) dispReg <= countInc;
         end
      end
   end

   assign sw.display   = dispReg;
   assign sw.running   = active;
   assign sw.lapActive = (state == LAP_HOLD);
   assign sw.overflow  = ovfReg;
endmodule

// File: tb/tb_bcd_stopwatch.sv
// Drives two stopwatches (1 and 5 ticks per count) from shared stimulus and
// scores display and status against hand-computed expectations.
module tb_bcd_stopwatch;
   logic clkIn = 1'b0;
   logic rst = 1'b1;
   logic slowClk = 1'b0, startStop = 1'b0, lap = 1'b0, clear = 1'b0;

   always #5 clkIn = ~clkIn;

   bcd_stopwatch_if if1 ();
   bcd_stopwatch_if if5 ();

   assign if1.slowClk = slowClk;  assign if5.slowClk = slowClk;
   assign if1.startStop = startStop;  assign if5.startStop = startStop;
   assign if1.lap = lap;  assign if5.lap = lap;
   assign if1.clear = clear;  assign if5.clear = clear;

   bcd_stopwatch #(.TICKS_PER_COUNT(1)) dut1 (.clkIn(clkIn), .rst(rst), .sw(if1.slave));
   bcd_stopwatch #(.TICKS_PER_COUNT(5)) dut5 (.clkIn(clkIn), .rst(rst), .sw(if5.slave));

   // flags are {running, lapActive, overflow}
   typedef struct packed {
      logic [79:0] name;
      logic        ss, lp, clr;
      logic [15:0] edges;
      logic [3:0]  per;
      logic [15:0] d1;
      logic [2:0]  f1;
      logic [15:0] d5;
      logic [2:0]  f5;
   } vec_t;

   vec_t vecs[$];
   vec_t expQ[$];
   int nVec = 0, nMis = 0;

   function automatic vec_t mk(input logic [79:0] name, input logic ss, lp, clr,
                               input int edges, per, input logic [15:0] d1,
                               input logic [2:0] f1, input logic [15:0] d5,
                               input logic [2:0] f5);
      vec_t v;
      v.name = name; v.ss = ss; v.lp = lp; v.clr = clr;
      v.edges = 16'(edges); v.per = 4'(per);
      v.d1 = d1; v.f1 = f1; v.d5 = d5; v.f5 = f5;
      return v;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clkIn);
   endtask

   task automatic check(input vec_t v);
      logic [2:0] a1, a5;
      a1 = {if1.running, if1.lapActive, if1.overflow};
      a5 = {if5.running, if5.lapActive, if5.overflow};
      nVec++;
      if (if1.display !== v.d1 || a1 !== v.f1 || if5.display !== v.d5 || a5 !== v.f5) begin
         nMis++;
         $display("FAIL %0s: x1 disp=%h flags=%b want %h/%b; x5 disp=%h flags=%b want %h/%b",
                  v.name, if1.display, a1, v.d1, v.f1, if5.display, a5, v.d5, v.f5);
      end
   endtask

   task automatic apply(input vec_t v);
      expQ.push_back(v);
      if (v.ss || v.lp) begin
         startStop = v.ss; lap = v.lp; cyc(2);
         startStop = 1'b0; lap = 1'b0; cyc(2);
      end
      if (v.clr) begin
         clear = 1'b1; cyc(1); clear = 1'b0; cyc(1);
      end
      for (int i = 0; i < int'(v.edges); i++) begin
         slowClk = 1'b1; cyc(int'(v.per) / 2);
         slowClk = 1'b0; cyc(int'(v.per) / 2);
      end
      cyc(4);
      check(expQ.pop_front());
   endtask

   initial begin
      cyc(1);
      rst = 1'b1;
      repeat (4) begin slowClk = ~slowClk; cyc(1); end
      rst = 1'b0; slowClk = 1'b0;
      cyc(3);
      expQ.push_back(mk("reset", 0, 0, 0, 0, 0, 16'h0000, 3'b000, 16'h0000, 3'b000));
      check(expQ.pop_front());

      vecs.push_back(mk("idle",     0, 0, 0,     3, 8, 16'h0000, 3'b000, 16'h0000, 3'b000));
      vecs.push_back(mk("start",    1, 0, 0,    12, 8, 16'h0012, 3'b100, 16'h0002, 3'b100));
      vecs.push_back(mk("stop",     1, 0, 0,     4, 8, 16'h0012, 3'b000, 16'h0002, 3'b000));
      vecs.push_back(mk("lapClr",   0, 1, 0,     0, 8, 16'h0000, 3'b000, 16'h0000, 3'b000));
      vecs.push_back(mk("run23",    1, 0, 0,    23, 8, 16'h0023, 3'b100, 16'h0004, 3'b100));
      vecs.push_back(mk("run2",     0, 0, 0,     2, 8, 16'h0025, 3'b100, 16'h0005, 3'b100));
      vecs.push_back(mk("lapFrz",   0, 1, 0,     3, 8, 16'h0025, 3'b110, 16'h0005, 3'b110));
      vecs.push_back(mk("lapRel",   0, 1, 0,     0, 8, 16'h0028, 3'b100, 16'h0005, 3'b100));
      vecs.push_back(mk("stop2",    1, 0, 0,     0, 8, 16'h0028, 3'b000, 16'h0005, 3'b000));
      vecs.push_back(mk("lapStop",  0, 1, 0,     0, 8, 16'h0000, 3'b000, 16'h0000, 3'b000));
      vecs.push_back(mk("wrap",     1, 0, 0, 10000, 4, 16'h0000, 3'b101, 16'h2000, 3'b100));
      vecs.push_back(mk("ssLap",    1, 1, 0,     0, 8, 16'h0000, 3'b001, 16'h2000, 3'b000));
      vecs.push_back(mk("lapOvf",   0, 1, 0,     0, 8, 16'h0000, 3'b000, 16'h0000, 3'b000));
      vecs.push_back(mk("run5",     1, 0, 0,     5, 8, 16'h0005, 3'b100, 16'h0001, 3'b100));
      vecs.push_back(mk("lap2",     0, 1, 0,     2, 8, 16'h0005, 3'b110, 16'h0001, 3'b110));
      vecs.push_back(mk("clrHold",  0, 0, 1,     0, 8, 16'h0000, 3'b000, 16'h0000, 3'b000));
      vecs.push_back(mk("afterClr", 0, 0, 0,     3, 8, 16'h0000, 3'b000, 16'h0000, 3'b000));
      vecs.push_back(mk("to42",     1, 0, 0,    42, 8, 16'h0042, 3'b100, 16'h0008, 3'b100));

      foreach (vecs[i]) apply(vecs[i]);

      // reset lands on the same posedge that would apply a tick
      slowClk = 1'b1; cyc(1);
      cyc(1);
      rst = 1'b1; cyc(1);
      slowClk = 1'b0;
      expQ.push_back(mk("rstTick", 0, 0, 0, 0, 0, 16'h0000, 3'b000, 16'h0000, 3'b000));
      check(expQ.pop_front());
      rst = 1'b0;
      cyc(4);
      expQ.push_back(mk("postRst", 0, 0, 0, 0, 0, 16'h0000, 3'b000, 16'h0000, 3'b000));
      check(expQ.pop_front());

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end
endmodule
